// File: rtl/riscv_div_unit_pkg.sv
// rtl/riscv_div_unit_pkg.sv - ISA divide encodings and divider microarchitecture types
package riscv_div_unit_pkg;

  localparam int CPU_DATA_BITS = 32;

  localparam logic [2:0] FNC_DIV  = 3'b100;
  localparam logic [2:0] FNC_DIVU = 3'b101;
  localparam logic [2:0] FNC_REM  = 3'b110;
  localparam logic [2:0] FNC_REMU = 3'b111;

  // Named so trace and debug tooling can decode the divider state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module riscv_div_unit
  import riscv_div_unit_pkg::*;
#(
  parameter int XLEN     = CPU_DATA_BITS,
  parameter int TAG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [TAG_BITS-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [TAG_BITS-1:0] out_tag
);

  localparam int CNT_BITS = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t            state;
  logic [CNT_BITS-1:0]   cnt;
  logic [XLEN-1:0]       rem_q;
  logic [XLEN-1:0]       quo_q;
  logic [XLEN-1:0]       dvsr_q;
  logic                  is_rem_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [TAG_BITS-1:0]   tag_q;

  logic                  unused_funct3;
  logic                  op_rem;
  logic                  op_signed;
  logic                  div_zero;
  logic                  overflow;
  logic [XLEN-1:0]       fast_data;
  logic [XLEN-1:0]       abs_rs1;
  logic [XLEN-1:0]       abs_rs2;

  logic [XLEN:0]         rem_sh;
  logic [XLEN:0]         trial;
  logic [XLEN-1:0]       rem_nxt;
  logic [XLEN-1:0]       quo_nxt;
  logic [XLEN-1:0]       quo_fix;
  logic [XLEN-1:0]       rem_fix;

  assign unused_funct3 = in_funct3[2];
  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);

  always_comb begin
    op_rem    = in_funct3[1];
    op_signed = ~in_funct3[0];
    div_zero  = (in_rs2 == '0);
    overflow  = op_signed && (in_rs1 == MIN_NEG) && (&in_rs2);
    fast_data = '0;
    if (div_zero) begin
      fast_data = op_rem ? in_rs1 : '1;
    end else if (overflow) begin
      fast_data = op_rem ? '0 : MIN_NEG;
    end
    abs_rs1 = (op_signed && in_rs1[XLEN-1]) ? (~in_rs1 + 1'b1) : in_rs1;
    abs_rs2 = (op_signed && in_rs2[XLEN-1]) ? (~in_rs2 + 1'b1) : in_rs2;
  end

  // One restoring step; the extra top bit of trial is the borrow.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, dvsr_q};
    rem_nxt = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};
    quo_fix = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tag_q    <= in_tag;
            is_rem_q <= op_rem;
            if (div_zero || overflow) begin
              out_data <= fast_data;
              out_tag  <= in_tag;
              state    <= DONE;
            end else begin
              quo_q     <= abs_rs1;
              dvsr_q    <= abs_rs2;
              rem_q     <= '0;
              neg_quo_q <= op_signed && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
              neg_rem_q <= op_signed && in_rs1[XLEN-1];
              cnt       <= CNT_BITS'(XLEN - 1);
              state     <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            out_data <= is_rem_q ? rem_fix : quo_fix;
            out_tag  <= tag_q;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb/tb_riscv_div_unit.sv - directed table-driven bench for riscv_div_unit
module tb_riscv_div_unit;
  import riscv_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;

  int pass_cnt = 0;
  int total_cnt = 0;

  riscv_div_unit #(.XLEN(32), .TAG_BITS(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Presents an op and returns at the negedge after its accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_tag    = t;
    @(negedge clk);
    in_valid  = 1'b0;
    in_rs1    = 32'hDEAD_BEEF;
    in_rs2    = 32'h1234_5678;
    in_tag    = 6'h3F;
  endtask

  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_checked(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [5:0] t,
                             input logic [31:0] exp, input int lat);
    int edges;
    issue(f, a, b, t);
    wait_valid(edges);
    chk({name, "_latency"}, edges, lat);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, {26'd0, out_tag}, {26'd0, t});
    if (out_valid) consume();
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int          edges;
    int          bad;
    logic [31:0] held_data;
    logic [5:0]  held_tag;

    vecs[0]  = '{FNC_DIV,  32'd100,        32'd7,          6'd5,  32'd14,         33};
    vecs[1]  = '{FNC_REM,  32'hFFFF_FFF9,  32'h0000_0002,  6'd6,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{FNC_DIV,  32'hFFFF_FFF9,  32'h0000_0002,  6'd7,  32'hFFFF_FFFD,  33};
    vecs[3]  = '{FNC_DIVU, 32'd5,          32'd0,          6'd8,  32'hFFFF_FFFF,  1};
    vecs[4]  = '{FNC_REMU, 32'd5,          32'd0,          6'd9,  32'd5,          1};
    vecs[5]  = '{FNC_DIVU, 32'hFFFF_FFFF,  32'd1,          6'd10, 32'hFFFF_FFFF,  33};
    vecs[6]  = '{FNC_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  6'd11, 32'h8000_0000,  1};
    vecs[7]  = '{FNC_REM,  32'h8000_0000,  32'hFFFF_FFFF,  6'd12, 32'd0,          1};
    vecs[8]  = '{FNC_DIV,  32'd5,          32'd0,          6'd13, 32'hFFFF_FFFF,  1};
    vecs[9]  = '{FNC_REM,  32'hFFFF_FFFB,  32'd0,          6'd14, 32'hFFFF_FFFB,  1};
    vecs[10] = '{FNC_REMU, 32'd100,        32'd7,          6'd15, 32'd2,          33};
    vecs[11] = '{FNC_DIV,  32'h8000_0000,  32'd1,          6'd16, 32'h8000_0000,  33};
    vecs[12] = '{FNC_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  6'd17, 32'd0,          33};
    vecs[13] = '{FNC_REM,  32'd7,          32'hFFFF_FFFE,  6'd18, 32'd1,          33};
    vecs[14] = '{FNC_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  6'd19, 32'd14,         33};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'd0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_tag", {26'd0, out_tag}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_checked($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                  vecs[i].tag, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result must hold while out_ready is low.
    issue(FNC_DIV, 32'd100, 32'd7, 6'd3);
    wait_valid(edges);
    chk("bp_latency", edges, 33);
    held_data = out_data;
    held_tag  = out_tag;
    chk("bp_data", held_data, 32'd14);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_data !== held_data || out_tag !== held_tag || in_ready !== 1'b0 ||
          out_valid !== 1'b1) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    consume();

    // Flush in IDLE with a pending op: nothing may be accepted.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = FNC_DIVU; in_rs1 = 32'd5; in_rs2 = 32'd0; in_tag = 6'd40;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);
    expect_no_valid("idle_flush_no_valid", 3);

    // Flush at CALC cycle 10.
    issue(FNC_DIV, 32'd100, 32'd7, 6'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    expect_no_valid("flush_no_valid_later", 40);
    run_checked("post_flush", FNC_DIVU, 32'd9, 32'd3, 6'd21, 32'd3, 33);

    // Reset at CALC cycle 10.
    issue(FNC_DIV, 32'd100, 32'd7, 6'd22);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_calc_out_data", out_data, 32'd0);
    chk("rst_calc_out_tag", {26'd0, out_tag}, 32'd0);
    expect_no_valid("rst_calc_no_valid", 40);
    run_checked("post_rst", FNC_DIVU, 32'd9, 32'd3, 6'd23, 32'd3, 33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU. It consumes issued operands plus funct3, which the decoder takes from the shared ISA encodings.
- Produces one tagged result per operation toward writeback/ROB, with valid/ready on both sides.
- Single operation in flight; multi-cycle; supports flush.

Parameters:
- XLEN, 32 (= CPU_DATA_BITS): operand/result width.
- TAG_BITS, 6: width of the destination/ROB tag carried with the op.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or completed-but-unconsumed op.
- in_valid  in  1  issue side has an op.
- in_ready  out  1  unit can accept an op.
- in_funct3  in  3  FNC_DIV/DIVU/REM/REMU encoding.
- in_rs1  in  XLEN  dividend.
- in_rs2  in  XLEN  divisor.
- in_tag  in  TAG_BITS  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts result.
- out_data  out  XLEN  quotient or remainder.
- out_tag  out  TAG_BITS  tag of the result.

Behaviour:
- States: IDLE, CALC, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset (rst=1 at an edge): state to IDLE. out_valid=0, in_ready=1 next cycle. out_data and out_tag cleared to 0. Iteration counter cleared to 0.
- Priority at an edge: rst > flush > handshake/iteration.
- Accept: an op is accepted on an edge where in_valid && in_ready && !flush. Operands, tag and funct3 are latched; values outside that edge are ignored.
- funct3 decode:
  - bit1 = 1 selects remainder; bit1 = 0 selects quotient.
  - bit0 = 1 selects unsigned; bit0 = 0 selects signed.
  - bit2 is ignored; the issue logic routes only M-extension divide codes here.
- Fast path (accepting edge goes IDLE->DONE, latency 1 edge):
  - Divisor == 0: quotient = all ones (DIV and DIVU); remainder = dividend (REM and REMU).
  - Signed op with dividend == 0x80000000 and divisor == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path:
  - Accepting edge goes IDLE->CALC. It latches |rs1| and |rs2| (magnitudes for signed, raw values for unsigned), clears the partial remainder, and sets the counter to XLEN-1.
  - Each CALC edge: shift {rem, quo} left by 1; trial = rem_shifted - divisor, computed XLEN+1 bits wide.
    - If trial is non-negative: rem = trial and quo LSB = 1.
    - Otherwise: rem is kept and quo LSB = 0.
    - Then decrement the counter.
  - The edge where the counter == 0 performs the final iteration and goes CALC->DONE. It applies sign correction at the same time:
    - Quotient is negated if signed and rs1 sign != rs2 sign.
    - Remainder is negated if signed and rs1 was negative.
  - Total latency: XLEN+1 edges from the accepting edge to out_valid=1 (33 for XLEN=32).
- DONE:
  - out_data and out_tag are held stable until out_valid && out_ready.
  - On that edge, DONE->IDLE. in_ready rises the following cycle, so there is no same-edge re-accept.
- Flush:
  - In CALC or DONE: goes to IDLE on that edge; the result is discarded and out_valid=0 next cycle.
  - In IDLE with in_valid=1: nothing is accepted.
- Reset mid-CALC: behaves identically to reset from IDLE, with no residual output.
- Arithmetic is modulo 2^XLEN. The intermediate subtract is XLEN+1 bits so the borrow is observable. The minimum-value magnitude 0x80000000 is handled correctly as unsigned.

Decomposition:
- Shared ISA package: reuse the existing FNC_DIV/DIVU/REM/REMU and CPU_DATA_BITS constants; add nothing there.
- Shared microarchitecture package: add div_state_t (enum IDLE/CALC/DONE) so trace and debug tooling can decode it.
- No sub-module. A single flat module is appropriate; the one-bit restoring step is a small combinational block inside it.

Test Plan:
- DIV 100 / 7 (in_funct3=100): out_valid exactly 33 edges after accept; out_data = 14; tag echoed.
- REM -7 / 2 (0xFFFFFFF9, 0x00000002): out_data = 0xFFFFFFFF (-1). Same operands with DIV: out_data = 0xFFFFFFFD (-3).
- DIVU 5 / 0: out_valid 1 edge after accept, out_data = 0xFFFFFFFF. REMU 5 / 0: out_data = 5. DIVU 0xFFFFFFFF / 1: out_data = 0xFFFFFFFF after 33 edges.
- DIV 0x80000000 / 0xFFFFFFFF: out_data = 0x80000000 after 1 edge. REM with the same operands: out_data = 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid. out_data/out_tag must be stable and in_ready must stay 0; after the handshake edge, in_ready=1 the next cycle.
- Flush at CALC cycle 10 (and a separate run with rst at CALC cycle 10): out_valid never asserts for that op. in_ready=1 next cycle. A following DIVU 9 / 3 returns 3 with the correct new tag.
